// File: rtl/uart_memif_bridge.sv
// UART byte-command to memory-interface bridge: decodes READ/WRITE commands from received bytes,
// issues one memory request per command and streams a status (plus read data) response back.
module uart_memif_bridge #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        g_clk,
   input  logic        g_reset,
   output logic        g_clk_req,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        memif_req,
   input  logic        memif_gnt,
   output logic        memif_wen,
   output logic [3:0]  memif_strb,
   output logic [31:0] memif_addr,
   output logic [31:0] memif_wdata,
   input  logic [31:0] memif_rdata,
   input  logic        memif_error,
   output logic        overrun
);

   localparam logic [7:0]  OpRead    = 8'h01;
   localparam logic [7:0]  OpWrite   = 8'h02;
   localparam logic [7:0]  StsOk     = 8'h00;
   localparam logic [7:0]  StsTmo    = 8'h02;
   localparam logic [7:0]  StsBadOp  = 8'hFF;
   localparam logic [15:0] TmoLast   = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {StIdle, StAddr, StData, StReq, StRsp, StSend} state_e;

   state_e       state_q, state_d;
   logic         op_write_q;
   logic [1:0]   cnt_q;
   logic [31:0]  addr_q;
   logic [31:0]  wdata_q;
   logic [31:0]  rdata_q;
   logic [7:0]   status_q;
   logic [15:0]  tmo_q;
   logic [2:0]   byte_idx_q;
   logic [2:0]   last_idx_q;
   logic         overrun_q;

   logic         is_op;
   logic         tmo_hit;
   logic         last_byte;
   logic         rsp_has_data;
   logic [7:0]   send_byte;

   assign is_op        = (rx_data == OpRead) || (rx_data == OpWrite);
   assign tmo_hit      = (tmo_q == TmoLast);
   assign last_byte    = (byte_idx_q == last_idx_q);
   assign rsp_has_data = !op_write_q && !memif_error;

   // State register
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (rx_valid) begin
               state_d = is_op ? StAddr : StSend;
            end
         end
         StAddr: begin
            if (rx_valid && (cnt_q == 2'd3)) begin
               state_d = op_write_q ? StData : StReq;
            end
         end
         StData: begin
            if (rx_valid && (cnt_q == 2'd3)) begin
               state_d = StReq;
            end
         end
         StReq: begin
            if (memif_gnt) begin
               state_d = StRsp;
            end else if (tmo_hit) begin
               state_d = StSend;
            end
         end
         StRsp: state_d = StSend;
         StSend: begin
            if (tx_ready && last_byte) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      send_byte = status_q;
      unique case (byte_idx_q)
         3'd1:    send_byte = rdata_q[7:0];
         3'd2:    send_byte = rdata_q[15:8];
         3'd3:    send_byte = rdata_q[23:16];
         3'd4:    send_byte = rdata_q[31:24];
         default: send_byte = status_q;
      endcase
   end

   // Output logic
   always_comb begin
      g_clk_req   = (state_q != StIdle) || rx_valid;
      memif_req   = (state_q == StReq);
      memif_wen   = memif_req && op_write_q;
      memif_strb  = (memif_req && op_write_q) ? 4'b1111 : 4'b0000;
      memif_addr  = {addr_q[31:2], 2'b00};
      memif_wdata = wdata_q;
      tx_valid    = (state_q == StSend);
      tx_data     = tx_valid ? send_byte : 8'h00;
      overrun     = overrun_q;
   end

   // Datapath: field capture, timeout counting and response sequencing
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         op_write_q <= 1'b0;
         cnt_q      <= 2'd0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         rdata_q    <= 32'h0;
         status_q   <= 8'h00;
         tmo_q      <= 16'd0;
         byte_idx_q <= 3'd0;
         last_idx_q <= 3'd0;
         overrun_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (rx_valid) begin
                  byte_idx_q <= 3'd0;
                  if (is_op) begin
                     op_write_q <= (rx_data == OpWrite);
                     cnt_q      <= 2'd0;
                  end else begin
                     status_q   <= StsBadOp;
                     last_idx_q <= 3'd0;
                  end
               end
            end
            StAddr: begin
               if (rx_valid) begin
                  addr_q[{cnt_q, 3'b000} +: 8] <= rx_data;
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            StData: begin
               if (rx_valid) begin
                  wdata_q[{cnt_q, 3'b000} +: 8] <= rx_data;
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            StReq: begin
               if (memif_gnt) begin
                  tmo_q <= 16'd0;
               end else if (tmo_hit) begin
                  tmo_q      <= 16'd0;
                  status_q   <= StsTmo;
                  last_idx_q <= 3'd0;
                  byte_idx_q <= 3'd0;
               end else begin
                  tmo_q <= tmo_q + 16'd1;
               end
            end
            StRsp: begin
               status_q   <= memif_error ? 8'h01 : StsOk;
               last_idx_q <= rsp_has_data ? 3'd4 : 3'd0;
               byte_idx_q <= 3'd0;
               if (rsp_has_data) begin
                  rdata_q <= memif_rdata;
               end
            end
            StSend: begin
               if (tx_ready) begin
                  byte_idx_q <= byte_idx_q + 3'd1;
               end
            end
            default: ;
         endcase
         // Bytes arriving while a command is in flight are dropped, including the SEND->IDLE cycle
         if (rx_valid && ((state_q == StReq) || (state_q == StRsp) || (state_q == StSend))) begin
            overrun_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_memif_bridge.sv
// Scoreboard bench for uart_memif_bridge: directed commands push expected memory requests and
// response bytes; a negedge monitor pops and compares on every handshake.
module tb_uart_memif_bridge;

   logic        g_clk = 1'b0;
   logic        g_reset;
   logic        g_clk_req;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        memif_req;
   logic        memif_gnt;
   logic        memif_wen;
   logic [3:0]  memif_strb;
   logic [31:0] memif_addr;
   logic [31:0] memif_wdata;
   logic [31:0] memif_rdata;
   logic        memif_error;
   logic        overrun;

   typedef struct packed {
      logic        wen;
      logic [3:0]  strb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_t;

   mem_t       exp_mem[$];
   logic [7:0] exp_tx[$];
   int         vectors = 0;
   int         fails = 0;
   int         req_cycles = 0;
   logic       hold_pend = 1'b0;
   logic [7:0] hold_data = 8'h00;

   uart_memif_bridge #(.TIMEOUT(4)) dut (
      .g_clk       (g_clk),
      .g_reset     (g_reset),
      .g_clk_req   (g_clk_req),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_data     (tx_data),
      .memif_req   (memif_req),
      .memif_gnt   (memif_gnt),
      .memif_wen   (memif_wen),
      .memif_strb  (memif_strb),
      .memif_addr  (memif_addr),
      .memif_wdata (memif_wdata),
      .memif_rdata (memif_rdata),
      .memif_error (memif_error),
      .overrun     (overrun)
   );

   always #5 g_clk = ~g_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares each memory grant and each tx handshake against the scoreboard
   always @(negedge g_clk) begin
      mem_t e;
      logic [7:0] b;
      if (memif_req) req_cycles++;
      if (memif_req && memif_gnt) begin
         if (exp_mem.size() == 0) begin
            vectors++;
            fails++;
            $display("FAIL mem_unexpected: got addr %h, expected no request", memif_addr);
         end else begin
            e = exp_mem.pop_front();
            check("mem_addr", memif_addr, e.addr);
            check("mem_wen", {31'd0, memif_wen}, {31'd0, e.wen});
            check("mem_strb", {28'd0, memif_strb}, {28'd0, e.strb});
            if (e.wen) check("mem_wdata", memif_wdata, e.wdata);
         end
      end
      if (hold_pend && tx_valid) check("tx_hold", {24'd0, tx_data}, {24'd0, hold_data});
      hold_pend = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (tx_valid && tx_ready) begin
         if (exp_tx.size() == 0) begin
            vectors++;
            fails++;
            $display("FAIL tx_unexpected: got %h, expected no byte", tx_data);
         end else begin
            b = exp_tx.pop_front();
            check("tx_byte", {24'd0, tx_data}, {24'd0, b});
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge g_clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] rd, input logic err);
      mem_t e;
      e.wen = 1'b0; e.strb = 4'b0000; e.addr = {a[31:2], 2'b00}; e.wdata = 32'h0;
      if (memif_gnt) exp_mem.push_back(e);
      memif_rdata = rd;
      memif_error = err;
      send_byte(8'h01);
      send_word(a);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      mem_t e;
      e.wen = 1'b1; e.strb = 4'b1111; e.addr = {a[31:2], 2'b00}; e.wdata = d;
      exp_mem.push_back(e);
      exp_tx.push_back(8'h00);
      send_byte(8'h02);
      send_word(a);
      send_word(d);
   endtask

   task automatic wait_done();
      int n = 0;
      while ((exp_tx.size() != 0 || exp_mem.size() != 0 || tx_valid) && n < 300) begin
         @(posedge g_clk);
         #2;
         n++;
      end
      check("drain", exp_tx.size() + exp_mem.size(), 0);
      repeat (2) @(posedge g_clk);
      #1;
   endtask

   task automatic push_read_rsp(input logic [31:0] rd);
      exp_tx.push_back(8'h00);
      for (int i = 0; i < 4; i++) exp_tx.push_back(rd[i*8 +: 8]);
   endtask

   initial begin
      int n;
      g_reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
      memif_gnt = 1'b1; memif_rdata = 32'h0; memif_error = 1'b0;
      repeat (3) @(posedge g_clk);
      #1;
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_req", {31'd0, memif_req}, 32'd0);
      check("rst_wen_strb", {27'd0, memif_wen, memif_strb}, 32'd0);
      check("rst_addr", memif_addr, 32'd0);
      check("rst_wdata", memif_wdata, 32'd0);
      check("rst_clk_req", {31'd0, g_clk_req}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      g_reset = 1'b0;
      @(posedge g_clk);
      #1;

      // Clock request must follow rx_valid combinationally while idle
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      #1;
      check("clk_req_rx", {31'd0, g_clk_req}, 32'd1);
      rx_valid = 1'b0;
      #1;
      check("clk_req_idle", {31'd0, g_clk_req}, 32'd0);
      @(posedge g_clk);
      #1;

      // Read 0x20000010 -> 00 EF BE AD DE
      push_read_rsp(32'hDEADBEEF);
      do_read(32'h2000_0010, 32'hDEADBEEF, 1'b0);
      wait_done();

      // Write 0x00000007 (word 0x4) <- 0x11223344 -> 00
      do_write(32'h0000_0007, 32'h1122_3344);
      wait_done();

      // Read with memory error -> 01
      exp_tx.push_back(8'h01);
      do_read(32'h0000_000C, 32'hCAFEF00D, 1'b1);
      wait_done();
      memif_error = 1'b0;

      // Timeout with gnt held low: four request cycles then 02
      memif_gnt = 1'b0;
      req_cycles = 0;
      exp_tx.push_back(8'h02);
      do_read(32'h0000_0100, 32'h0, 1'b0);
      wait_done();
      check("tmo_req_cycles", req_cycles, 32'd4);
      memif_gnt = 1'b1;

      // Unknown opcode -> FF, held stable under backpressure, no memory request
      req_cycles = 0;
      tx_ready = 1'b0;
      exp_tx.push_back(8'hFF);
      send_byte(8'h55);
      repeat (3) @(posedge g_clk);
      #1;
      check("bad_tx_valid", {31'd0, tx_valid}, 32'd1);
      check("bad_tx_data", {24'd0, tx_data}, 32'hFF);
      tx_ready = 1'b1;
      wait_done();
      check("bad_no_req", req_cycles, 32'd0);

      // Extra byte during SEND sets overrun without disturbing the response
      tx_ready = 1'b0;
      push_read_rsp(32'h0BAD_F00D);
      do_read(32'h0000_0040, 32'h0BAD_F00D, 1'b0);
      n = 0;
      while (!tx_valid && n < 50) begin
         @(posedge g_clk);
         #1;
         n++;
      end
      check("ovr_reach_send", {31'd0, tx_valid}, 32'd1);
      send_byte(8'h02);
      check("ovr_set", {31'd0, overrun}, 32'd1);
      tx_ready = 1'b1;
      wait_done();
      do_write(32'h0000_0100, 32'hDDCC_BBAA);
      wait_done();
      check("ovr_sticky", {31'd0, overrun}, 32'd1);

      // Reset while memif_req is high aborts silently
      memif_gnt = 1'b0;
      do_read(32'h0000_0080, 32'h0, 1'b0);
      n = 0;
      while (!memif_req && n < 50) begin
         @(posedge g_clk);
         #1;
         n++;
      end
      check("rst_req_seen", {31'd0, memif_req}, 32'd1);
      @(posedge g_clk);
      #1;
      g_reset = 1'b1;
      @(posedge g_clk);
      #1;
      check("rst_mid_req", {31'd0, memif_req}, 32'd0);
      check("rst_mid_ovr", {31'd0, overrun}, 32'd0);
      g_reset = 1'b0;
      repeat (4) @(posedge g_clk);
      #1;
      check("rst_mid_no_tx", {31'd0, tx_valid}, 32'd0);
      memif_gnt = 1'b1;
      do_write(32'h0000_0008, 32'h5566_7788);
      wait_done();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1);
   end

endmodule
